// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing one SBA system-bus master port among NrMasters requesters,
// with one outstanding transaction, owner locking and an optional response timeout.
module dm_sba_arbiter #(
  parameter int unsigned NrMasters     = 2,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrMasters-1:0]                 req_i,
  input  logic [NrMasters-1:0]                 we_i,
  input  logic [NrMasters-1:0][BusWidth-1:0]   add_i,
  input  logic [NrMasters-1:0][BusWidth-1:0]   wdata_i,
  input  logic [NrMasters-1:0][BusWidth/8-1:0] be_i,
  output logic [NrMasters-1:0]                 gnt_o,
  output logic [NrMasters-1:0]                 r_valid_o,
  output logic                                 r_err_o,
  output logic                                 r_other_err_o,
  output logic [BusWidth-1:0]                  r_rdata_o,
  output logic                                 master_req_o,
  output logic [BusWidth-1:0]                  master_add_o,
  output logic                                 master_we_o,
  output logic [BusWidth-1:0]                  master_wdata_o,
  output logic [BusWidth/8-1:0]                master_be_o,
  input  logic                                 master_gnt_i,
  input  logic                                 master_r_valid_i,
  input  logic                                 master_r_err_i,
  input  logic                                 master_r_other_err_i,
  input  logic [BusWidth-1:0]                  master_r_rdata_i,
  output logic                                 timeout_o
);

  localparam int unsigned IdxW = $clog2(NrMasters);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   winner;
  logic              any_req;
  logic [IdxW-1:0]   sel;
  logic              fwd;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(NrMasters - 1)) ? '0 : i + IdxW'(1);
  endfunction

  // First active requester at or above rr_ptr, wrapping around.
  always_comb begin : winner_search
    int unsigned idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NrMasters; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NrMasters) idx = idx - NrMasters;
      if (!any_req && req_i[IdxW'(idx)]) begin
        any_req = 1'b1;
        winner  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    cnt_d          = '0;
    sel            = owner_q;
    fwd            = 1'b0;
    gnt_o          = '0;
    r_valid_o      = '0;
    r_err_o        = 1'b0;
    r_other_err_o  = 1'b0;
    r_rdata_o      = '0;
    master_req_o   = 1'b0;
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    timeout_o      = 1'b0;

    // Outputs are held at zero while reset is asserted, even with requests pending.
    if (rst_ni) begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            fwd          = 1'b1;
            sel          = winner;
            master_req_o = 1'b1;
            owner_d      = winner;
            if (master_gnt_i) begin
              gnt_o[winner] = 1'b1;
              rr_ptr_d      = next_idx(winner);
              state_d       = WAIT;
            end else begin
              state_d = REQ;
            end
          end
        end
        REQ: begin
          fwd          = 1'b1;
          master_req_o = req_i[owner_q];
          if (!req_i[owner_q]) begin
            state_d = IDLE;
          end else if (master_gnt_i) begin
            gnt_o[owner_q] = 1'b1;
            rr_ptr_d       = next_idx(owner_q);
            state_d        = WAIT;
          end
        end
        WAIT: begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
          if (master_r_valid_i) begin
            r_valid_o[owner_q] = 1'b1;
            r_err_o            = master_r_err_i;
            r_other_err_o      = master_r_other_err_i;
            r_rdata_o          = master_r_rdata_i;
            cnt_d              = '0;
            state_d            = IDLE;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            r_valid_o[owner_q] = 1'b1;
            r_other_err_o      = 1'b1;
            timeout_o          = 1'b1;
            cnt_d              = '0;
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (fwd) begin
        master_add_o   = add_i[sel];
        master_we_o    = we_i[sel];
        master_wdata_o = wdata_i[sel];
        master_be_o    = be_i[sel];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
